// File: rtl/music_seq_player.sv
// music_seq_player: plays a tune stored in a writable song RAM.
//   Each song entry is {dur, note}: a 5-bit note code in [4:0] and a DUR_W-bit
//   duration in beats above it. The player walks entries 0..play_len-1 and
//   drives a square wave on audio. It can loop, and it pulses done when a
//   non-looping song ends.
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   wr_en/wr_addr/     song RAM write port, usable in any state
//   wr_data
//   play_len, loop_en  song length (1..DEPTH) and loop flag, sampled on start
//   start, stop        start request (acted on only when idle), abort
//   audio              square-wave output
//   busy               high whenever the player is not idle
//   done               one-cycle pulse at the natural end of a non-looping song
//   cur_idx            index of the entry being played
module music_seq_player #(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned TEMPO_HZ = 4,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned DUR_W    = 4,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [5+DUR_W-1:0]   wr_data,
    input  logic [AW:0]          play_len,
    input  logic                 loop_en,
    input  logic                 start,
    input  logic                 stop,
    output logic                 audio,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        cur_idx
);

    localparam int unsigned BEAT_DIV = CLK_HZ / TEMPO_HZ;
    localparam int unsigned BW       = $clog2(BEAT_DIV + 1);
    // The lowest pitch (262 Hz) has the longest half period.
    localparam int unsigned TW       = $clog2(CLK_HZ / (2 * 262) + 1);

    function automatic int unsigned freq_hz(input int unsigned n);
        case (n)
            1:  freq_hz = 262;
            2:  freq_hz = 294;
            3:  freq_hz = 330;
            4:  freq_hz = 349;
            5:  freq_hz = 392;
            6:  freq_hz = 440;
            7:  freq_hz = 494;
            8:  freq_hz = 523;
            9:  freq_hz = 587;
            10: freq_hz = 659;
            11: freq_hz = 698;
            12: freq_hz = 784;
            13: freq_hz = 880;
            14: freq_hz = 988;
            15: freq_hz = 1047;
            16: freq_hz = 1175;
            17: freq_hz = 1319;
            18: freq_hz = 1397;
            19: freq_hz = 1568;
            20: freq_hz = 1760;
            21: freq_hz = 1976;
            default: freq_hz = 0;
        endcase
    endfunction

    // Zero half period marks a rest.
    function automatic int unsigned half_const(input int unsigned f);
        if (f == 0) return 0;
        return CLK_HZ / (2 * f);
    endfunction

    logic [TW-1:0] half_tab [32];

    for (genvar g = 0; g < 32; g++) begin : g_half
        assign half_tab[g] = TW'(half_const(freq_hz(g)));
    end

    // Song RAM: synchronous write, registered read of the current index.
    logic [5+DUR_W-1:0] mem [DEPTH];
    logic [5+DUR_W-1:0] rd_data;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[cur_idx];
    end

    typedef enum logic [1:0] {IDLE, RD, LAT, PLAY} state_t;

    state_t             state;
    logic [AW:0]        len_q;
    logic               loop_q;
    logic [TW-1:0]      half_q;
    logic [TW-1:0]      tone_cnt;
    logic [BW-1:0]      beat_cnt;
    logic [DUR_W-1:0]   beats_left;

    logic               start_ok;
    logic               last_entry;
    logic [DUR_W-1:0]   rd_dur;

    always_comb begin
        start_ok   = (play_len != '0) && (play_len <= (AW+1)'(DEPTH));
        last_entry = ({1'b0, cur_idx} == len_q - (AW+1)'(1));
        rd_dur     = rd_data[5 +: DUR_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            audio      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cur_idx    <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            half_q     <= '0;
            tone_cnt   <= '0;
            beat_cnt   <= '0;
            beats_left <= '0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state <= IDLE;
                audio <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        audio <= 1'b0;
                        if (start && start_ok) begin
                            len_q   <= play_len;
                            loop_q  <= loop_en;
                            cur_idx <= '0;
                            busy    <= 1'b1;
                            state   <= RD;
                        end
                    end
                    RD: begin
                        state <= LAT;
                    end
                    LAT: begin
                        half_q     <= half_tab[rd_data[4:0]];
                        beats_left <= (rd_dur == '0) ? DUR_W'(1) : rd_dur;
                        tone_cnt   <= '0;
                        beat_cnt   <= '0;
                        audio      <= 1'b0;
                        state      <= PLAY;
                    end
                    PLAY: begin
                        if (half_q == '0) begin
                            audio <= 1'b0;
                        end else if (tone_cnt == half_q - TW'(1)) begin
                            tone_cnt <= '0;
                            audio    <= ~audio;
                        end else begin
                            tone_cnt <= tone_cnt + TW'(1);
                        end

                        if (beat_cnt == BW'(BEAT_DIV - 1)) begin
                            beat_cnt <= '0;
                            if (beats_left == DUR_W'(1)) begin
                                // Note over: silence the pin through RD/LAT
                                // of the next entry, overriding any toggle.
                                audio <= 1'b0;
                                if (!last_entry) begin
                                    cur_idx <= cur_idx + AW'(1);
                                    state   <= RD;
                                end else if (loop_q) begin
                                    cur_idx <= '0;
                                    state   <= RD;
                                end else begin
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    state <= IDLE;
                                end
                            end else begin
                                beats_left <= beats_left - DUR_W'(1);
                            end
                        end else begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
